// File: rtl/dphy_pkg.sv
// Shared encodings for the D-PHY data lane transmit path:
// FSM states, sync byte and LP line levels ({Dp, Dn}).
package dphy_pkg;

    typedef enum logic [2:0] {
        ST_STOP,
        ST_LPX01,
        ST_PREP,
        ST_HS_ZERO,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL,
        ST_EXIT
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    function automatic logic [1:0] lp_level(input tx_state_e s);
        logic [1:0] lv;
        lv = LP00;
        unique case (s)
            ST_STOP, ST_EXIT: lv = LP11;
            ST_LPX01:         lv = LP01;
            default:          lv = LP00;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/hs_tx_shifter.sv
// 8-bit load/shift register for the HS serial stream, LSB first,
// with a bit index that flags the last and next-to-last bit.
module hs_tx_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] load_data,
    output logic       dout,
    output logic       last,
    output logic       near_last
);

    logic [7:0] data_q, data_d;
    logic [2:0] idx_q, idx_d;

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (load) begin
            data_d = load_data;
            idx_d  = 3'd0;
        end else if (shift) begin
            data_d = {1'b0, data_q[7:1]};
            idx_d  = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 8'h00;
            idx_q  <= 3'd0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

    assign dout      = data_q[0];
    assign last      = (idx_q == 3'd7);
    assign near_last = (idx_q == 3'd6);

endmodule

// File: rtl/hs_tx_serializer.sv
// D-PHY data lane HS transmitter: LP start sequence, sync,
// LSB-first payload serialization, trail and exit.
module hs_tx_serializer
    import dphy_pkg::*;
#(
    parameter int T_LPX        = 2,
    parameter int T_HS_PREPARE = 3,
    parameter int T_HS_ZERO    = 5,
    parameter int T_HS_TRAIL   = 4,
    parameter int T_HS_EXIT    = 3
) (
    input  logic       TxBitClkHS,
    input  logic       TxRstN,
    input  logic       TxRequestHS,
    input  logic [7:0] TxDataHS,
    output logic       TxReadyHS,
    output logic       TxHsDout,
    output logic       TxHsEn,
    output logic       TxLpDp,
    output logic       TxLpDn,
    output logic       TxStopState
);

    localparam int T_M1 = (T_LPX > T_HS_PREPARE) ? T_LPX : T_HS_PREPARE;
    localparam int T_M2 = (T_M1 > T_HS_ZERO) ? T_M1 : T_HS_ZERO;
    localparam int T_M3 = (T_M2 > T_HS_TRAIL) ? T_M2 : T_HS_TRAIL;
    localparam int T_MAX = (T_M3 > T_HS_EXIT) ? T_M3 : T_HS_EXIT;
    localparam int CW = $clog2(T_MAX + 1);

    typedef logic [CW-1:0] cnt_t;

    tx_state_e  state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       start_q, start_d;
    logic       ready_q, ready_d;
    logic       hs_en_q, hs_en_d;
    logic       stop_q, stop_d;
    logic [1:0] lp_q, lp_d;

    logic       sh_load, sh_shift;
    logic [7:0] sh_data;
    logic       sh_dout, sh_last, sh_near_last;
    logic       cnt_zero, in_bits;

    assign cnt_zero = (cnt_q == '0);
    assign in_bits  = (state_q == ST_SYNC) || (state_q == ST_DATA);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_data  = 8'h00;
        unique case (state_q)
            ST_STOP: begin
                if (start_q) begin
                    state_d = ST_LPX01;
                    cnt_d   = cnt_t'(T_LPX - 1);
                end
            end
            ST_LPX01: begin
                if (cnt_zero) begin
                    state_d = ST_PREP;
                    cnt_d   = cnt_t'(T_HS_PREPARE - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_PREP: begin
                if (cnt_zero) begin
                    state_d = ST_HS_ZERO;
                    cnt_d   = cnt_t'(T_HS_ZERO - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_HS_ZERO: begin
                if (cnt_zero) begin
                    state_d = ST_SYNC;
                    sh_load = 1'b1;
                    sh_data = SYNC_BYTE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_SYNC, ST_DATA: begin
                if (!sh_last) begin
                    sh_shift = 1'b1;
                end else if (ready_q) begin
                    state_d = ST_DATA;
                    sh_load = 1'b1;
                    sh_data = TxDataHS;
                end else begin
                    // Shifter holds the inverted last bit as the trail level
                    state_d = ST_TRAIL;
                    cnt_d   = cnt_t'(T_HS_TRAIL - 1);
                    sh_load = 1'b1;
                    sh_data = {8{~sh_dout}};
                end
            end
            ST_TRAIL: begin
                if (cnt_zero) begin
                    state_d = ST_EXIT;
                    cnt_d   = cnt_t'(T_HS_EXIT - 1);
                    sh_load = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_EXIT: begin
                if (cnt_zero) begin
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
        endcase
    end

    always_comb begin
        start_d = TxRequestHS && (state_q == ST_STOP);
        ready_d = TxRequestHS && in_bits && sh_near_last;
        lp_d    = lp_level(state_d);
        hs_en_d = state_d inside {ST_HS_ZERO, ST_SYNC, ST_DATA, ST_TRAIL};
        stop_d  = (state_d == ST_STOP);
    end

    always_ff @(posedge TxBitClkHS or negedge TxRstN) begin
        if (!TxRstN) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            start_q <= 1'b0;
            ready_q <= 1'b0;
            hs_en_q <= 1'b0;
            stop_q  <= 1'b1;
            lp_q    <= LP11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            ready_q <= ready_d;
            hs_en_q <= hs_en_d;
            stop_q  <= stop_d;
            lp_q    <= lp_d;
        end
    end

    hs_tx_shifter u_shifter (
        .clk       (TxBitClkHS),
        .rst_n     (TxRstN),
        .load      (sh_load),
        .shift     (sh_shift),
        .load_data (sh_data),
        .dout      (sh_dout),
        .last      (sh_last),
        .near_last (sh_near_last)
    );

    assign TxReadyHS   = ready_q;
    assign TxHsDout    = sh_dout;
    assign TxHsEn      = hs_en_q;
    assign TxLpDp      = lp_q[1];
    assign TxLpDn      = lp_q[0];
    assign TxStopState = stop_q;

endmodule
